decode_issue_stage: RTL and testbench
=====================================

# decode_issue_stage

Registered RV32I decode-and-issue stage sitting between the fetch/ID pipeline register and the EX stage. It decodes one instruction per cycle into an EX control bundle and detects RAW hazards against all in-flight writers with a per-register scoreboard, not just the adjacent stage. It redirects fetch on JAL and holds issue while a JALR or branch resolves. Valid/ready handshakes on both sides; width and in-flight depth are parametrised.

## Interface
- XLEN, 32, data/PC width
- MAX_INFLIGHT, 3, max issued-but-not-written-back register writers (1..7)
- CNT_W, $clog2(MAX_INFLIGHT+1), per-register pending counter width (derived, not overridden)
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low
- in_valid / in_ready  in / out  1 / 1  ID-side handshake
- in_pc / in_instr  in  XLEN / 32  PC and instruction word
- out_valid / out_ready  out / in  1 / 1  EX-side handshake
- out_ctrl  out  ex_ctrl_t  ALUOp[2:0], ALUsrc[1:0], MemRead, MemWrite, MemToReg, RegWrite, func3[2:0], func7b, illegal
- out_rs1 / out_rs2 / out_rd  out  5 each  register specifiers
- out_imm / out_pc  out  XLEN each  sign-extended immediate, PC of instruction
- wb_valid / wb_rd  in  1 / 5  write-back retire, one per cycle
- resolve  in  1  one-cycle pulse: outstanding JALR/branch resolved in EX
- flush  in  1  kill the instruction held in the output register
- redirect / redirect_pc  out  1 / XLEN  registered one-cycle fetch redirect

## Operation
- Decode: R-type ALUOp 010 ALUsrc 00; I-ALU 011/01; LUI 100/01; AUIPC 101/10; loads 000/01 MemRead MemToReg; stores 000/01 MemWrite; branches 001/00; JAL 110, JALR 111, both RegWrite=1 (link). Immediates per RV32I I/S/B/U/J formats, sign-extended to XLEN. Unknown opcode: illegal=1, all write/mem enables 0, still issued.
- RegWrite forced 0 when rd = x0; x0 never pending.
- Scoreboard: pend[r] CNT_W-bit counter plus total counter. Hazard if any used source (rs1, and rs2 for R/S/B) has pend != 0, or total = MAX_INFLIGHT and instruction writes a register.
- Issue (in_valid && in_ready): pend[rd]++ if RegWrite. wb_valid: pend[wb_rd]--. Same rd same cycle: net unchanged. wb_valid with pend = 0 ignored (no underflow).
- flush: clears out_valid; if flushed entry had RegWrite, its pend[rd] is decremented that cycle. Flush and issue in one cycle: flush wins, no issue.
- FSM: RUN, SHADOW, WAIT.
  - RUN, issue JAL -> redirect=1 next cycle, redirect_pc = pc + imm; go SHADOW.
  - SHADOW: next accepted input beat is discarded (no issue, no scoreboard change) -> RUN.
  - RUN, issue JALR/branch -> WAIT; in_ready=0 until resolve -> RUN. flush in any state -> RUN.
- in_ready = (!out_valid || out_ready) && !hazard && state != WAIT (SHADOW ignores hazard).

## Timing
- Reset: out_valid 0, all out_* 0, redirect 0, redirect_pc 0, every counter 0, state RUN.
- Latency 1 cycle in->out; throughput 1/cycle without hazards.
- out_* stable while out_valid && !out_ready.
- Reset mid-operation clears scoreboard; pending write-backs after reset are ignored by the no-underflow rule.
- Write-back and dependent decode same cycle: decrement visible next cycle (no bypass, one-cycle bubble).

## Structure
- Package decode_pkg: ex_ctrl_t, ALUOp/ALUsrc encodings, opcode constants, state enum.
- Sub-module decode_scoreboard: counters, hazard output, issue/retire/flush-undo ports.
- Decode logic and FSM in the top module.

## Test plan
- ADDI x1,x0,5 then ADD x2,x1,x1 with no wb: second stalls. wb_rd=1 -> issues next cycle with rs1=rs2=1.
- Four independent writers to x1..x4, MAX_INFLIGHT=3: fourth stalls until any wb_valid. A store with no rd issues meanwhile.
- JAL at pc 0x100, imm 0x20: redirect pulse, redirect_pc 0x120; following beat dropped; out_rd = link rd.
- BEQ issued: in_ready 0 until resolve. flush instead returns to RUN and drops the output entry.
- Flush of held ADDI x5: pend[x5] returns to 0. A later instruction reading x5 issues without stall.
- Reset asserted during WAIT with pend nonzero: all outputs 0 and in_ready 1 on the first idle cycle after release.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared types and encodings for the RV32I decode-and-issue stage.
package decode_pkg;

    typedef struct packed {
        logic [2:0] alu_op;
        logic [1:0] alu_src;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic [2:0] func3;
        logic       func7b;
        logic       illegal;
    } ex_ctrl_t;

    localparam logic [2:0] ALU_MEM   = 3'b000;
    localparam logic [2:0] ALU_BR    = 3'b001;
    localparam logic [2:0] ALU_R     = 3'b010;
    localparam logic [2:0] ALU_I     = 3'b011;
    localparam logic [2:0] ALU_LUI   = 3'b100;
    localparam logic [2:0] ALU_AUIPC = 3'b101;
    localparam logic [2:0] ALU_JAL   = 3'b110;
    localparam logic [2:0] ALU_JALR  = 3'b111;

    localparam logic [1:0] SRC_RS2 = 2'b00;
    localparam logic [1:0] SRC_IMM = 2'b01;
    localparam logic [1:0] SRC_PC  = 2'b10;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // Issue FSM: RUN normal, SHADOW drops the beat after a JAL, WAIT holds for resolve.
    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_SHADOW = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;

endpackage

// File: rtl/decode_scoreboard.sv
// Per-register pending-writer counters plus an in-flight total; flags RAW and capacity hazards.
module decode_scoreboard #(
    parameter int MAX_INFLIGHT = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rs1_i,
    input  logic [4:0] rs2_i,
    input  logic       use_rs1_i,
    input  logic       use_rs2_i,
    input  logic       writes_i,
    input  logic       issue_we_i,
    input  logic [4:0] issue_rd_i,
    input  logic       undo_we_i,
    input  logic [4:0] undo_rd_i,
    input  logic       wb_valid_i,
    input  logic [4:0] wb_rd_i,
    output logic       hazard_o
);

    localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
    localparam logic [CNT_W:0] CNT_ONE = (CNT_W + 1)'(1);

    logic [CNT_W-1:0] pend_q [32];
    logic [CNT_W-1:0] pend_d [32];
    logic [CNT_W-1:0] total_q, total_d;
    logic [CNT_W:0]   cnt_tmp, tot_tmp;

    assign hazard_o = (use_rs1_i && pend_q[rs1_i] != '0)
                   || (use_rs2_i && pend_q[rs2_i] != '0)
                   || (writes_i && total_q == CNT_W'(MAX_INFLIGHT));

    // Increment first so an issue and a retire of the same rd in one cycle cancel;
    // decrements only apply to a nonzero count, so stale retires are ignored.
    always_comb begin
        pend_d  = pend_q;
        tot_tmp = {1'b0, total_q};
        cnt_tmp = '0;
        for (int r = 1; r < 32; r++) begin
            cnt_tmp = {1'b0, pend_q[r]};
            if (issue_we_i && issue_rd_i == 5'(r)) begin
                cnt_tmp = cnt_tmp + CNT_ONE;
                tot_tmp = tot_tmp + CNT_ONE;
            end
            if (undo_we_i && undo_rd_i == 5'(r) && cnt_tmp != '0) begin
                cnt_tmp = cnt_tmp - CNT_ONE;
                tot_tmp = tot_tmp - CNT_ONE;
            end
            if (wb_valid_i && wb_rd_i == 5'(r) && cnt_tmp != '0) begin
                cnt_tmp = cnt_tmp - CNT_ONE;
                tot_tmp = tot_tmp - CNT_ONE;
            end
            pend_d[r] = cnt_tmp[CNT_W-1:0];
        end
        total_d = tot_tmp[CNT_W-1:0];
    end

    // NOTE: state uses <= so every flop samples pre-edge values; the counter array is
    // flops (not RAM) precisely so reset can clear it and restart the scoreboard clean.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < 32; r++) pend_q[r] <= '0;
            total_q <= '0;
        end else begin
            pend_q  <= pend_d;
            total_q <= total_d;
        end
    end

endmodule

// File: rtl/decode_issue_stage.sv
// RV32I decode-and-issue stage: registered EX bundle, scoreboard hazards, JAL redirect, branch hold.
module decode_issue_stage
    import decode_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int MAX_INFLIGHT = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output ex_ctrl_t        out_ctrl,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_pc,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    input  logic            resolve,
    input  logic            flush,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc
);

    logic [6:0]      opcode;
    logic [4:0]      rs1, rs2, rd;
    ex_ctrl_t        dec_ctrl;
    logic [XLEN-1:0] dec_imm;
    logic            use_rs1, use_rs2, is_jal, is_hold;
    logic            hazard, accept, issue;

    logic            out_valid_q;
    ex_ctrl_t        out_ctrl_q;
    logic [4:0]      out_rs1_q, out_rs2_q, out_rd_q;
    logic [XLEN-1:0] out_imm_q, out_pc_q;
    logic            redirect_q;
    logic [XLEN-1:0] redirect_pc_q;
    logic [1:0]      state_q, state_d;

    assign opcode = in_instr[6:0];
    assign rd     = in_instr[11:7];
    assign rs1    = in_instr[19:15];
    assign rs2    = in_instr[24:20];

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        dec_ctrl        = '0;
        dec_ctrl.func3  = in_instr[14:12];
        dec_ctrl.func7b = in_instr[30];
        dec_imm         = '0;
        use_rs1         = 1'b0;
        use_rs2         = 1'b0;
        is_jal          = 1'b0;
        is_hold         = 1'b0;
        case (opcode)
            OP_R: begin
                dec_ctrl.alu_op = ALU_R;  dec_ctrl.alu_src = SRC_RS2;
                dec_ctrl.reg_write = 1'b1;
                use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            OP_I: begin
                dec_ctrl.alu_op = ALU_I;  dec_ctrl.alu_src = SRC_IMM;
                dec_ctrl.reg_write = 1'b1;
                dec_imm = XLEN'($signed(in_instr[31:20]));
                use_rs1 = 1'b1;
            end
            OP_LUI: begin
                dec_ctrl.alu_op = ALU_LUI; dec_ctrl.alu_src = SRC_IMM;
                dec_ctrl.reg_write = 1'b1;
                dec_imm = XLEN'($signed({in_instr[31:12], 12'b0}));
            end
            OP_AUIPC: begin
                dec_ctrl.alu_op = ALU_AUIPC; dec_ctrl.alu_src = SRC_PC;
                dec_ctrl.reg_write = 1'b1;
                dec_imm = XLEN'($signed({in_instr[31:12], 12'b0}));
            end
            OP_LOAD: begin
                dec_ctrl.alu_op = ALU_MEM; dec_ctrl.alu_src = SRC_IMM;
                dec_ctrl.mem_read = 1'b1; dec_ctrl.mem_to_reg = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                dec_imm = XLEN'($signed(in_instr[31:20]));
                use_rs1 = 1'b1;
            end
            OP_STORE: begin
                dec_ctrl.alu_op = ALU_MEM; dec_ctrl.alu_src = SRC_IMM;
                dec_ctrl.mem_write = 1'b1;
                dec_imm = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
                use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            OP_BRANCH: begin
                dec_ctrl.alu_op = ALU_BR; dec_ctrl.alu_src = SRC_RS2;
                dec_imm = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                         in_instr[11:8], 1'b0}));
                use_rs1 = 1'b1; use_rs2 = 1'b1;
                is_hold = 1'b1;
            end
            OP_JAL: begin
                dec_ctrl.alu_op = ALU_JAL; dec_ctrl.alu_src = SRC_RS2;
                dec_ctrl.reg_write = 1'b1;
                dec_imm = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                         in_instr[30:21], 1'b0}));
                is_jal = 1'b1;
            end
            OP_JALR: begin
                dec_ctrl.alu_op = ALU_JALR; dec_ctrl.alu_src = SRC_IMM;
                dec_ctrl.reg_write = 1'b1;
                dec_imm = XLEN'($signed(in_instr[31:20]));
                use_rs1 = 1'b1;
                is_hold = 1'b1;
            end
            default: dec_ctrl.illegal = 1'b1;
        endcase
        if (rd == 5'd0) dec_ctrl.reg_write = 1'b0;
    end

    decode_scoreboard #(.MAX_INFLIGHT(MAX_INFLIGHT)) u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .rs1_i      (rs1),
        .rs2_i      (rs2),
        .use_rs1_i  (use_rs1),
        .use_rs2_i  (use_rs2),
        .writes_i   (dec_ctrl.reg_write),
        .issue_we_i (issue && dec_ctrl.reg_write),
        .issue_rd_i (rd),
        .undo_we_i  (flush && out_valid_q && out_ctrl_q.reg_write),
        .undo_rd_i  (out_rd_q),
        .wb_valid_i (wb_valid),
        .wb_rd_i    (wb_rd),
        .hazard_o   (hazard)
    );

    // flush is folded into in_ready so a flushed cycle never handshakes a beat it would drop.
    assign in_ready = (!out_valid_q || out_ready) && !flush
                   && (state_q == ST_SHADOW || !hazard) && (state_q != ST_WAIT);
    assign accept   = in_valid && in_ready;
    assign issue    = accept && (state_q == ST_RUN);

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (issue && is_jal)       state_d = ST_SHADOW;
                    else if (issue && is_hold) state_d = ST_WAIT;
                end
                ST_SHADOW: if (accept)  state_d = ST_RUN;
                ST_WAIT:   if (resolve) state_d = ST_RUN;
                default:   state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q   <= 1'b0;
            out_ctrl_q    <= '0;
            out_rs1_q     <= '0;
            out_rs2_q     <= '0;
            out_rd_q      <= '0;
            out_imm_q     <= '0;
            out_pc_q      <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            state_q       <= ST_RUN;
        end else begin
            state_q    <= state_d;
            redirect_q <= issue && is_jal;
            if (issue && is_jal) redirect_pc_q <= in_pc + dec_imm;
            if (flush) begin
                out_valid_q <= 1'b0;
            end else if (issue) begin
                out_valid_q <= 1'b1;
                out_ctrl_q  <= dec_ctrl;
                out_rs1_q   <= rs1;
                out_rs2_q   <= rs2;
                out_rd_q    <= rd;
                out_imm_q   <= dec_imm;
                out_pc_q    <= in_pc;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign out_ctrl    = out_ctrl_q;
    assign out_rs1     = out_rs1_q;
    assign out_rs2     = out_rs2_q;
    assign out_rd      = out_rd_q;
    assign out_imm     = out_imm_q;
    assign out_pc      = out_pc_q;
    assign redirect    = redirect_q;
    assign redirect_pc = redirect_pc_q;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed self-checking bench for decode_issue_stage with hand-computed expectations.
module tb_decode_issue_stage;
    import decode_pkg::*;

    localparam logic [31:0] ADDI_X1_5  = 32'h0050_0093;
    localparam logic [31:0] ADD_X2_X1  = 32'h0010_8133;
    localparam logic [31:0] ADDI_X1_1  = 32'h0010_0093;
    localparam logic [31:0] ADDI_X2_1  = 32'h0010_0113;
    localparam logic [31:0] ADDI_X3_1  = 32'h0010_0193;
    localparam logic [31:0] ADDI_X4_1  = 32'h0010_0213;
    localparam logic [31:0] ADDI_X5_1  = 32'h0010_0293;
    localparam logic [31:0] ADDI_X6_1  = 32'h0010_0313;
    localparam logic [31:0] ADDI_X7_X5 = 32'h0002_8393;
    localparam logic [31:0] ADDI_X8_1  = 32'h0010_0413;
    localparam logic [31:0] SW_X0      = 32'h0000_2023;
    localparam logic [31:0] JAL_X1_32  = 32'h0200_00EF;
    localparam logic [31:0] BEQ_8      = 32'h0000_0463;
    localparam logic [31:0] LUI_X9     = 32'h1234_54B7;
    localparam logic [31:0] NOP        = 32'h0000_0013;
    localparam logic [31:0] BAD_OP     = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0, in_ready;
    logic [31:0] in_pc = '0, in_instr = '0;
    logic        out_valid, out_ready = 1'b1;
    ex_ctrl_t    out_ctrl;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic [31:0] out_imm, out_pc;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic        resolve = 1'b0, flush = 1'b0;
    logic        redirect;
    logic [31:0] redirect_pc;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    decode_issue_stage #(.XLEN(32), .MAX_INFLIGHT(3)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_imm(out_imm), .out_pc(out_pc),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .resolve(resolve), .flush(flush),
        .redirect(redirect), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr);
        in_valid = v;
        in_pc    = pc;
        in_instr = instr;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; in_valid = 1'b0; flush = 1'b0; wb_valid = 1'b0;
        resolve = 1'b0; out_ready = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        #1;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_ctrl", 64'(out_ctrl), 64'd0);
        check("rst_out_imm", 64'(out_imm), 64'd0);
        check("rst_redirect", 64'(redirect), 64'd0);
        check("rst_redirect_pc", 64'(redirect_pc), 64'd0);
        reset = 1'b1;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // RAW stall on x1 until write-back, one-cycle bubble after wb
        drive(1'b1, 32'h0, ADDI_X1_5);
        check("addi_ready", 64'(in_ready), 64'd1);
        tick();
        check("addi_valid", 64'(out_valid), 64'd1);
        check("addi_rd", 64'(out_rd), 64'd1);
        check("addi_imm", 64'(out_imm), 64'd5);
        check("addi_aluop", 64'(out_ctrl.alu_op), 64'b011);
        check("addi_alusrc", 64'(out_ctrl.alu_src), 64'b01);
        check("addi_regwrite", 64'(out_ctrl.reg_write), 64'd1);
        drive(1'b1, 32'h4, ADD_X2_X1);
        check("raw_stall", 64'(in_ready), 64'd0);
        tick();
        check("raw_bubble", 64'(out_valid), 64'd0);
        wb_valid = 1'b1; wb_rd = 5'd1;
        #1;
        check("wb_no_bypass", 64'(in_ready), 64'd0);
        tick();
        wb_valid = 1'b0;
        #1;
        check("raw_release", 64'(in_ready), 64'd1);
        tick();
        check("add_valid", 64'(out_valid), 64'd1);
        check("add_rs1", 64'(out_rs1), 64'd1);
        check("add_rs2", 64'(out_rs2), 64'd1);
        check("add_rd", 64'(out_rd), 64'd2);
        check("add_aluop", 64'(out_ctrl.alu_op), 64'b010);
        drive(1'b0, 32'h0, NOP);

        // In-flight capacity: fourth writer stalls, store slips through
        do_reset();
        drive(1'b1, 32'h10, ADDI_X1_1); tick();
        drive(1'b1, 32'h14, ADDI_X2_1); tick();
        drive(1'b1, 32'h18, ADDI_X3_1);
        check("third_writer_ready", 64'(in_ready), 64'd1);
        tick();
        drive(1'b1, 32'h1c, ADDI_X4_1);
        check("inflight_full", 64'(in_ready), 64'd0);
        drive(1'b1, 32'h20, SW_X0);
        check("store_ready", 64'(in_ready), 64'd1);
        tick();
        check("store_valid", 64'(out_valid), 64'd1);
        check("store_memwrite", 64'(out_ctrl.mem_write), 64'd1);
        check("store_regwrite", 64'(out_ctrl.reg_write), 64'd0);
        check("store_pc", 64'(out_pc), 64'h20);
        drive(1'b1, 32'h1c, ADDI_X4_1);
        check("fourth_still_stalled", 64'(in_ready), 64'd0);
        wb_valid = 1'b1; wb_rd = 5'd2;
        tick();
        wb_valid = 1'b0;
        #1;
        check("fourth_release", 64'(in_ready), 64'd1);
        tick();
        check("fourth_rd", 64'(out_rd), 64'd4);
        check("fourth_pc", 64'(out_pc), 64'h1c);
        drive(1'b0, 32'h0, NOP);

        // JAL redirect and shadow drop
        do_reset();
        drive(1'b1, 32'h100, JAL_X1_32);
        check("jal_ready", 64'(in_ready), 64'd1);
        tick();
        check("jal_valid", 64'(out_valid), 64'd1);
        check("jal_rd", 64'(out_rd), 64'd1);
        check("jal_imm", 64'(out_imm), 64'h20);
        check("jal_aluop", 64'(out_ctrl.alu_op), 64'b110);
        check("jal_regwrite", 64'(out_ctrl.reg_write), 64'd1);
        check("jal_redirect", 64'(redirect), 64'd1);
        check("jal_redirect_pc", 64'(redirect_pc), 64'h120);
        drive(1'b1, 32'h104, ADDI_X5_1);
        check("shadow_ready", 64'(in_ready), 64'd1);
        tick();
        check("shadow_dropped", 64'(out_valid), 64'd0);
        check("redirect_pulse_end", 64'(redirect), 64'd0);
        drive(1'b1, 32'h120, ADDI_X7_X5);
        check("shadow_no_pend", 64'(in_ready), 64'd1);
        tick();
        check("target_valid", 64'(out_valid), 64'd1);
        check("target_rd", 64'(out_rd), 64'd7);
        check("target_pc", 64'(out_pc), 64'h120);
        drive(1'b0, 32'h0, NOP);

        // Branch hold until resolve, then flush out of WAIT
        do_reset();
        drive(1'b1, 32'h200, BEQ_8);
        tick();
        check("beq_valid", 64'(out_valid), 64'd1);
        check("beq_aluop", 64'(out_ctrl.alu_op), 64'b001);
        check("beq_imm", 64'(out_imm), 64'd8);
        check("beq_regwrite", 64'(out_ctrl.reg_write), 64'd0);
        drive(1'b1, 32'h204, ADDI_X1_1);
        check("wait_hold", 64'(in_ready), 64'd0);
        tick();
        check("wait_no_issue", 64'(out_valid), 64'd0);
        resolve = 1'b1;
        #1;
        check("wait_resolve_cycle", 64'(in_ready), 64'd0);
        tick();
        resolve = 1'b0;
        #1;
        check("resolved_ready", 64'(in_ready), 64'd1);
        tick();
        check("after_resolve_rd", 64'(out_rd), 64'd1);
        drive(1'b1, 32'h300, BEQ_8);
        tick();
        out_ready = 1'b0;
        drive(1'b0, 32'h0, NOP);
        flush = 1'b1;
        #1;
        check("flush_blocks_ready", 64'(in_ready), 64'd0);
        tick();
        flush = 1'b0;
        #1;
        check("flush_kills_beq", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        drive(1'b1, 32'h304, ADDI_X8_1);
        check("flush_back_to_run", 64'(in_ready), 64'd1);
        tick();
        check("after_flush_rd", 64'(out_rd), 64'd8);
        drive(1'b0, 32'h0, NOP);

        // Held output, flush undo of pend[x5], misc decode
        do_reset();
        out_ready = 1'b0;
        drive(1'b1, 32'h400, ADDI_X5_1);
        tick();
        check("held_rd", 64'(out_rd), 64'd5);
        drive(1'b1, 32'h404, ADDI_X6_1);
        check("held_not_ready", 64'(in_ready), 64'd0);
        tick();
        check("held_stable_rd", 64'(out_rd), 64'd5);
        check("held_stable_pc", 64'(out_pc), 64'h400);
        drive(1'b0, 32'h0, NOP);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        check("held_flushed", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        drive(1'b1, 32'h408, ADDI_X7_X5);
        check("flush_undo_pend", 64'(in_ready), 64'd1);
        tick();
        check("x5_reader_rs1", 64'(out_rs1), 64'd5);
        drive(1'b1, 32'h40c, LUI_X9);
        tick();
        check("lui_imm", 64'(out_imm), 64'h1234_5000);
        check("lui_aluop", 64'(out_ctrl.alu_op), 64'b100);
        drive(1'b1, 32'h410, NOP);
        tick();
        check("x0_no_regwrite", 64'(out_ctrl.reg_write), 64'd0);
        drive(1'b1, 32'h414, BAD_OP);
        tick();
        check("illegal_flag", 64'(out_ctrl.illegal), 64'd1);
        check("illegal_regwrite", 64'(out_ctrl.reg_write), 64'd0);
        drive(1'b0, 32'h0, NOP);

        // Reset during WAIT with a pending writer
        do_reset();
        drive(1'b1, 32'h500, ADDI_X1_1); tick();
        drive(1'b1, 32'h504, BEQ_8); tick();
        drive(1'b1, 32'h508, ADDI_X2_1);
        check("pre_reset_wait", 64'(in_ready), 64'd0);
        reset = 1'b0;
        in_valid = 1'b0;
        #1;
        check("async_reset_valid", 64'(out_valid), 64'd0);
        tick();
        reset = 1'b1;
        #1;
        check("post_reset_ctrl", 64'(out_ctrl), 64'd0);
        check("post_reset_pc", 64'(out_pc), 64'd0);
        check("post_reset_rd", 64'(out_rd), 64'd0);
        check("post_reset_ready", 64'(in_ready), 64'd1);
        wb_valid = 1'b1; wb_rd = 5'd1;
        tick();
        wb_valid = 1'b0;
        drive(1'b1, 32'h600, ADDI_X1_1);
        tick();
        drive(1'b1, 32'h604, ADD_X2_X1);
        check("stale_wb_ignored", 64'(in_ready), 64'd0);
        drive(1'b0, 32'h0, NOP);
        tick();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
